// File: rtl/iob_eth_mdio.sv
// Clause-22 MII management master: serializes one read or write frame per request
// and generates MDC from the system clock with a programmable half-period.
module iob_eth_mdio (
    input  logic        clk_i,
    input  logic        cke_i,
    input  logic        rst_i,
    input  logic [7:0]  clkdiv_i,
    input  logic        nopre_i,
    input  logic        start_i,
    input  logic        wr_i,
    input  logic [4:0]  fiad_i,
    input  logic [4:0]  rgad_i,
    input  logic [15:0] wdata_i,
    output logic [15:0] rdata_o,
    output logic        rd_err_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        mdc_o,
    output logic        mdio_o,
    output logic        mdio_oe_o,
    input  logic        mdio_i
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRE  = 3'd1,
        S_HDR  = 3'd2,
        S_TA   = 3'd3,
        S_DATA = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [6:0]  h_q;
    logic        wr_q;
    logic [6:0]  cnt_q, cnt_d;
    logic [5:0]  bit_q, bit_d;
    logic [31:0] sh_q, sh_d;
    logic [15:0] rx_q, rx_d;
    logic        err_q, err_d;
    logic        mdc_q, mdc_d;
    logic        mdio_q, mdio_d;
    logic        oe_q, oe_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [15:0] rdata_q, rdata_d;
    logic        rd_err_q, rd_err_d;

    logic        accept_s, half_end_s, rise_s, bit_end_s, last_bit_s;
    logic [5:0]  last_idx_s;
    logic [6:0]  h_new_s;
    logic [31:0] sh_new_s;

    assign accept_s   = start_i && (state_q == S_IDLE);
    assign h_new_s    = (clkdiv_i[7:1] == 7'd0) ? 7'd1 : clkdiv_i[7:1];
    // Header through data; read TA/DATA slots are zero since the line is released there.
    assign sh_new_s   = {2'b01, (wr_i ? 2'b01 : 2'b10), fiad_i, rgad_i,
                         (wr_i ? 2'b10 : 2'b00), (wr_i ? wdata_i : 16'h0000)};
    assign half_end_s = (state_q != S_IDLE) && (cnt_q == (h_q - 7'd1));
    assign rise_s     = half_end_s && !mdc_q;
    assign bit_end_s  = half_end_s && mdc_q;
    assign last_bit_s = (bit_q == last_idx_s);

    // Last bit index of each field.
    always_comb begin
        case (state_q)
            S_PRE:   last_idx_s = 6'd31;
            S_HDR:   last_idx_s = 6'd13;
            S_TA:    last_idx_s = 6'd1;
            S_DATA:  last_idx_s = 6'd15;
            default: last_idx_s = 6'd0;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else if (cke_i) begin
            state_q <= state_d;
        end
    end

    // Next-state logic: fields advance at the end of their last bit.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) state_d = nopre_i ? S_HDR : S_PRE;
                else         state_d = S_IDLE;
            end
            S_PRE: begin
                if (bit_end_s && last_bit_s) state_d = S_HDR;
                else                         state_d = S_PRE;
            end
            S_HDR: begin
                if (bit_end_s && last_bit_s) state_d = S_TA;
                else                         state_d = S_HDR;
            end
            S_TA: begin
                if (bit_end_s && last_bit_s) state_d = S_DATA;
                else                         state_d = S_TA;
            end
            S_DATA: begin
                if (bit_end_s && last_bit_s) state_d = S_IDLE;
                else                         state_d = S_DATA;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output and datapath next values: MDC phase, shifter, sampling, completion.
    always_comb begin
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        sh_d     = sh_q;
        rx_d     = rx_q;
        err_d    = err_q;
        mdc_d    = mdc_q;
        mdio_d   = mdio_q;
        oe_d     = oe_q;
        done_d   = 1'b0;
        rdata_d  = rdata_q;
        rd_err_d = rd_err_q;
        busy_d   = (state_d != S_IDLE);
        if (accept_s) begin
            cnt_d  = 7'd0;
            bit_d  = 6'd0;
            sh_d   = sh_new_s;
            mdc_d  = 1'b0;
            oe_d   = 1'b1;
            mdio_d = nopre_i ? sh_new_s[31] : 1'b1;
        end else if (half_end_s) begin
            cnt_d = 7'd0;
            mdc_d = ~mdc_q;
            if (rise_s && !wr_q && (state_q == S_TA) && (bit_q == 6'd1)) begin
                err_d = mdio_i;
            end else if (rise_s && !wr_q && (state_q == S_DATA)) begin
                rx_d = {rx_q[14:0], mdio_i};
            end else begin
                rx_d = rx_q;
            end
            if (bit_end_s) begin
                bit_d = last_bit_s ? 6'd0 : (bit_q + 6'd1);
                if (state_d == S_IDLE) begin
                    mdc_d  = 1'b0;
                    mdio_d = 1'b0;
                    oe_d   = 1'b0;
                    done_d = 1'b1;
                    if (!wr_q) begin
                        rdata_d  = rx_q;
                        rd_err_d = err_q;
                    end else begin
                        rdata_d  = rdata_q;
                        rd_err_d = rd_err_q;
                    end
                end else begin
                    // Preamble bits come from a constant; the shifter only moves after it.
                    if (state_q != S_PRE) sh_d = {sh_q[30:0], 1'b0};
                    else                  sh_d = sh_q;
                    mdio_d = (state_d == S_PRE) ? 1'b1 :
                             ((state_q == S_PRE) ? sh_q[31] : sh_q[30]);
                    oe_d   = wr_q || (state_d == S_PRE) || (state_d == S_HDR);
                end
            end else begin
                bit_d = bit_q;
            end
        end else if (state_q != S_IDLE) begin
            cnt_d = cnt_q + 7'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            h_q      <= 7'd1;
            wr_q     <= 1'b0;
            cnt_q    <= 7'd0;
            bit_q    <= 6'd0;
            sh_q     <= 32'h0000_0000;
            rx_q     <= 16'h0000;
            err_q    <= 1'b0;
            mdc_q    <= 1'b0;
            mdio_q   <= 1'b0;
            oe_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            rdata_q  <= 16'h0000;
            rd_err_q <= 1'b0;
        end else if (cke_i) begin
            if (accept_s) begin
                h_q  <= h_new_s;
                wr_q <= wr_i;
            end
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            sh_q     <= sh_d;
            rx_q     <= rx_d;
            err_q    <= err_d;
            mdc_q    <= mdc_d;
            mdio_q   <= mdio_d;
            oe_q     <= oe_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            rdata_q  <= rdata_d;
            rd_err_q <= rd_err_d;
        end
    end

    assign rdata_o   = rdata_q;
    assign rd_err_o  = rd_err_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign mdc_o     = mdc_q;
    assign mdio_o    = mdio_q;
    assign mdio_oe_o = oe_q;

endmodule
